// File: rtl/mips_mem_arbiter.sv
// Round-robin arbiter sharing one single-ported word memory between the CPU
// instruction-fetch port and data port, one transaction at a time.
module mips_mem_arbiter #(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byteen,
  output logic        d_ack,
  output logic [31:0] d_rdata,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_byteenable,
  input  logic [31:0] mem_readdata,
  output logic        stall,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef enum logic {
    GNT_FETCH = 1'b0,
    GNT_DATA  = 1'b1
  } grant_t;

  localparam logic [3:0] CNT_LOAD = 4'(MEM_LATENCY - 1);

  state_t      state_q, state_d;
  grant_t      grant_q, grant_d;
  grant_t      last_grant_q, last_grant_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] mem_address_q, mem_address_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic [31:0] mem_writedata_q, mem_writedata_d;
  logic [3:0]  mem_byteenable_q, mem_byteenable_d;
  logic        i_ack_q, i_ack_d;
  logic        d_ack_q, d_ack_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;
  logic        fetch_win_s;
  logic        addr_lo_unused_s;

  // Fetch wins when alone, or on contention when data was served last.
  assign fetch_win_s      = i_req & (~d_req | (last_grant_q == GNT_DATA));
  assign addr_lo_unused_s = ^i_addr[1:0];

  // Next-state, grant and memory-strobe computation.
  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    last_grant_d     = last_grant_q;
    cnt_d            = cnt_q;
    mem_address_d    = mem_address_q;
    mem_read_d       = mem_read_q;
    mem_write_d      = mem_write_q;
    mem_writedata_d  = mem_writedata_q;
    mem_byteenable_d = mem_byteenable_q;
    i_ack_d          = 1'b0;
    d_ack_d          = 1'b0;
    i_rdata_d        = i_rdata_q;
    d_rdata_d        = d_rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (fetch_win_s) begin
          grant_d          = GNT_FETCH;
          last_grant_d     = GNT_FETCH;
          cnt_d            = CNT_LOAD;
          mem_address_d    = {i_addr[31:2], 2'b00};
          mem_read_d       = 1'b1;
          mem_write_d      = 1'b0;
          mem_writedata_d  = 32'h0000_0000;
          mem_byteenable_d = 4'hF;
          state_d          = ST_ACCESS;
        end else if (d_req) begin
          grant_d          = GNT_DATA;
          last_grant_d     = GNT_DATA;
          cnt_d            = CNT_LOAD;
          mem_address_d    = d_addr;
          mem_read_d       = ~d_write;
          mem_write_d      = d_write;
          mem_writedata_d  = d_wdata;
          mem_byteenable_d = d_byteen;
          state_d          = ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          // Writes leave the data-port read register untouched.
          if (mem_read_q && (grant_q == GNT_FETCH)) begin
            i_rdata_d = mem_readdata;
          end else if (mem_read_q) begin
            d_rdata_d = mem_readdata;
          end else begin
            d_rdata_d = d_rdata_q;
          end
          if (grant_q == GNT_FETCH) begin
            i_ack_d = 1'b1;
          end else begin
            d_ack_d = 1'b1;
          end
          mem_address_d    = 32'h0000_0000;
          mem_read_d       = 1'b0;
          mem_write_d      = 1'b0;
          mem_writedata_d  = 32'h0000_0000;
          mem_byteenable_d = 4'h0;
          state_d          = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q          <= ST_IDLE;
      grant_q          <= GNT_FETCH;
      last_grant_q     <= GNT_DATA;
      cnt_q            <= 4'd0;
      mem_address_q    <= 32'h0000_0000;
      mem_read_q       <= 1'b0;
      mem_write_q      <= 1'b0;
      mem_writedata_q  <= 32'h0000_0000;
      mem_byteenable_q <= 4'h0;
      i_ack_q          <= 1'b0;
      d_ack_q          <= 1'b0;
      i_rdata_q        <= 32'h0000_0000;
      d_rdata_q        <= 32'h0000_0000;
    end else begin
      state_q          <= state_d;
      grant_q          <= grant_d;
      last_grant_q     <= last_grant_d;
      cnt_q            <= cnt_d;
      mem_address_q    <= mem_address_d;
      mem_read_q       <= mem_read_d;
      mem_write_q      <= mem_write_d;
      mem_writedata_q  <= mem_writedata_d;
      mem_byteenable_q <= mem_byteenable_d;
      i_ack_q          <= i_ack_d;
      d_ack_q          <= d_ack_d;
      i_rdata_q        <= i_rdata_d;
      d_rdata_q        <= d_rdata_d;
    end
  end

  assign i_ack          = i_ack_q;
  assign d_ack          = d_ack_q;
  assign i_rdata        = i_rdata_q;
  assign d_rdata        = d_rdata_q;
  assign mem_address    = mem_address_q;
  assign mem_read       = mem_read_q;
  assign mem_write      = mem_write_q;
  assign mem_writedata  = mem_writedata_q;
  assign mem_byteenable = mem_byteenable_q;
  assign stall          = (i_req & ~i_ack_q) | (d_req & ~d_ack_q);
  assign busy           = (state_q != ST_IDLE);

endmodule
